cv32e40n_data_mem_resp: RTL
===========================

# cv32e40n_data_mem_resp

Responder (slave) end of the core's req/gnt/rvalid data interface. It sits behind the data crossbar's memory port and models a single-port word-addressed data RAM. It accepts one transaction per cycle and returns an in-order response a fixed LATENCY cycles after grant. It serves both CPU and NVPE traffic, and stores are also acknowledged with rvalid.

## Interface
- DEPTH, 1024: number of 32-bit words; must be a power of two ≥ 2.
- LATENCY, 1: cycles from grant to rvalid; legal range 1..4.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low; clock clk_i.
- data_req_i  in  1  request valid; the initiator holds it and all address-phase signals stable until granted.
- data_gnt_o  out  1  grant; the address phase is accepted on a cycle where req && gnt.
- data_addr_i  in  32  byte address; word index = addr[$clog2(DEPTH)+1:2]; bits [1:0] and the upper bits are ignored.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  byte enables for stores; ignored for loads, which always return the full word.
- data_wdata_i  in  32  store data.
- data_rvalid_o  out  1  response valid; one pulse per accepted transaction, in order.
- data_rdata_o  out  32  load data; 32'h0 on store responses and whenever rvalid is low.

## Operation
- Acceptance: a transaction is accepted in cycle T when data_req_i && data_gnt_o at the end of T.
- Store accepted in T: bytes with be[i]=1 are written at the closing edge of T; other bytes are unchanged. be=4'b0000 writes nothing and still produces a response.
- Load accepted in T: the word is sampled at the closing edge of T, after any write from an earlier cycle.
  - Load at T after store at T-1 to the same word returns the merged new data.
  - Store at T+1 after load at T does not affect that load's data.
- Response pipeline: LATENCY stages, each holding {valid, rdata}. Stage 0 is loaded on acceptance; for stores its rdata is 32'h0. The pipeline advances every cycle and never stalls; the initiator has no back-pressure on responses.
- Outstanding transactions: at most LATENCY, bounded by the pipeline. Back-to-back acceptance every cycle is legal.
- Grant: data_gnt_o = data_req_i && !stall. It is combinational from req, with no combinational path from addr, we or wdata. stall = 0 unless the Configuration feature is enabled.
- No error response; out-of-range addresses wrap modulo DEPTH.

## Timing
- Reset values: data_gnt_o = 0 while req is low, data_rvalid_o = 0, data_rdata_o = 0, all pipeline valid bits 0.
- RAM contents are not reset.
- Latency: accept in T → rvalid high during T+LATENCY, with rdata valid in that same cycle.
- LATENCY=1: rvalid is the registered acceptance, one cycle after the grant.
- Simultaneous events: a response leaving the pipeline and a new acceptance in the same cycle are independent and both are legal.
- Reset mid-operation: every in-flight response is discarded and no rvalid is issued after reset deasserts. RAM contents are retained, including writes accepted before reset asserted.
- Grant while req is low is 0; there are no speculative grants.

## Configuration
- DATA_MEM_RESP_STALL_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle.
  - stall = (lfsr[1:0] == 2'b00), giving roughly 25% grant back-pressure.
  - While stalled the initiator holds its request. The LFSR keeps advancing during reset release only from its seed.
- Undefined: no LFSR, stall = 0, and the grant is a pure wire from req.

## Structure
- Package cv32e40n_data_mem_pkg holds:
  - typedef resp_stage_t {logic valid; logic [31:0] rdata;}
  - localparam LFSR_SEED = 8'hA5
  - localparam LFSR_TAPS = 8'hB8
  - localparam MAX_LATENCY = 4
- Sub-module cv32e40n_data_mem_lfsr is instantiated only under DATA_MEM_RESP_STALL_EN. It has ports clk_i, rst_ni and lfsr_o[7:0].
- The RAM array and the response pipeline stay in the top module.

## Test plan
- Reset then idle, req=0: rvalid=0, rdata=0, gnt=0 for 10 cycles.
- Store addr 0x10, be=4'hF, wdata 0xDEADBEEF at T, then load 0x10 at T+1 (LATENCY=1): rvalid at T+1 with rdata 0; rvalid at T+2 with rdata 0xDEADBEEF.
- Store 0x10, be=4'b0101, wdata 0x11223344 over 0xDEADBEEF, then load: rdata 0xDE22BE44.
- LATENCY=3, 6 back-to-back loads to 0x0..0x14 preloaded with values 1..6: the first rvalid comes 3 cycles after the first grant, followed by 6 consecutive rvalids with rdata 1..6 in order.
- Assert rst_ni low for 1 cycle with 2 loads in flight: no rvalid afterwards. A subsequent load of a word written before reset returns the old data.
- With DATA_MEM_RESP_STALL_EN: hold req for 256 cycles and check that each grant matches lfsr[1:0]!=0 from seed 0xA5, and that each granted transaction yields exactly one in-order rvalid.

Source files
------------

// File: rtl/cv32e40n_data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its stall LFSR.
package cv32e40n_data_mem_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } resp_stage_t;

  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam int         MAX_LATENCY = 4;

endpackage

// File: rtl/cv32e40n_data_mem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that drives pseudo-random grant back-pressure.
module cv32e40n_data_mem_lfsr
  import cv32e40n_data_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [7:0] lfsr_o
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_lfsr <= LFSR_SEED;
    else         r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign lfsr_o = r_lfsr;

endmodule

// File: rtl/cv32e40n_data_mem_resp.sv
// Single-port word-addressed data RAM on the req/gnt/rvalid bus with a fixed-latency,
// never-stalling response pipeline. Define DATA_MEM_RESP_STALL_EN for LFSR grant back-pressure.
module cv32e40n_data_mem_resp
  import cv32e40n_data_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
);

  localparam int IDX_W = $clog2(DEPTH);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("LATENCY must be in 1..MAX_LATENCY");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  logic               w_stall;
  logic               w_accept;
  logic [IDX_W-1:0]   w_idx;
  logic               w_unused_addr;
  resp_stage_t        w_stage_in;
  resp_stage_t        w_stage_out;

  logic [31:0]        r_mem   [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [31:0]        r_rdata [LATENCY];

`ifdef DATA_MEM_RESP_STALL_EN
  logic [7:0] w_lfsr;
  logic       w_unused_lfsr;

  cv32e40n_data_mem_lfsr u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .lfsr_o (w_lfsr)
  );

  assign w_stall       = (w_lfsr[1:0] == 2'b00);
  assign w_unused_lfsr = ^w_lfsr[7:2];
`else
  assign w_stall = 1'b0;
`endif

  // Grant depends only on req and the stall source, never on the address phase.
  assign data_gnt_o = data_req_i && !w_stall;
  assign w_accept   = data_req_i && data_gnt_o;

  // Word index wraps modulo DEPTH; byte offset and upper address bits are don't-care.
  assign w_idx         = data_addr_i[IDX_W+1:2];
  assign w_unused_addr = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (w_accept && data_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Stage 0 input: loads sample the RAM at the acceptance edge; stores respond with zero.
  always_comb begin
    w_stage_in.valid = w_accept;
    w_stage_in.rdata = (w_accept && !data_we_i) ? r_mem[w_idx] : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= w_stage_in.valid;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    r_rdata[0] <= w_stage_in.rdata;
    for (int i = 1; i < LATENCY; i++) r_rdata[i] <= r_rdata[i-1];
  end

  // Output stage: rdata is forced to zero whenever no response is presented.
  always_comb begin
    w_stage_out.valid = r_vld[LATENCY-1];
    w_stage_out.rdata = r_vld[LATENCY-1] ? r_rdata[LATENCY-1] : 32'h0;
  end

  assign data_rvalid_o = w_stage_out.valid;
  assign data_rdata_o  = w_stage_out.rdata;

endmodule
